adpll_cpu_regs: RTL

ADPLL_CPU_REGS -- requirements
Module: adpll_cpu_regs

---
 rtl/adpll_cpu_regs.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/adpll_cpu_regs.sv
// adpll_cpu_regs: CPU register block configuring an ADPLL.
// Single-cycle request/acknowledge bus, lock synchronizer, lock-loss
// flag and a small IDLE/RUN/RESTART enable FSM.
// Optional feature: define ADPLL_LOCK_TIMEOUT_EN to build the lock timeout
// counter; when undefined the timeout bit reads as constant 0.
module adpll_cpu_regs #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int FCW_W        = 26,
    parameter int RESTART_CYC  = 4,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wstrb,
    output logic [1:0]        rdata,
    output logic              ready,
    input  logic              channel_lock,
    output logic [FCW_W-1:0]  fcw,
    output logic [1:0]        adpll_mode,
    output logic              en
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RESTART = 2'd2
    } state_t;

    localparam int RCNT_W = $clog2(RESTART_CYC + 1);
    // The restart countdown runs RESTART_CYC-1 .. 0, one state per cycle.
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(RESTART_CYC - 1);

    state_t            state;
    logic [RCNT_W-1:0] rcnt;
    logic              lock_meta;
    logic              lock_s;
    logic              lock_s_q;
    logic              lock_lost;
    logic              timeout;

    // A request is taken only while no acknowledge is pending, which
    // limits the bus to one transaction every two cycles.
    logic accept, wr, rd;
    logic sel_fcw, sel_mode, sel_en, sel_lock, sel_status;
    assign accept     = valid & ~ready;
    assign wr         = accept & wstrb;
    assign rd         = accept & ~wstrb;
    assign sel_fcw    = (address == ADDR_W'(0));
    assign sel_mode   = (address == ADDR_W'(1));
    assign sel_en     = (address == ADDR_W'(2));
    assign sel_lock   = (address == ADDR_W'(3));
    assign sel_status = (address == ADDR_W'(4));

    // Only the low bits of wdata feed registers; fold the rest away.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Two-flop synchronizer for channel_lock plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            lock_s_q  <= 1'b0;
        end else begin
            lock_meta <= channel_lock;
            lock_s    <= lock_meta;
            lock_s_q  <= lock_s;
        end
    end

    // Acknowledge and registered read data; rdata is zero outside the ready cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= 2'b00;
        end else begin
            ready <= accept;
            rdata <= 2'b00;
            if (rd && sel_lock)   rdata <= {timeout, lock_s};
            if (rd && sel_status) rdata <= {lock_lost, en};
        end
    end

    // Configuration registers and enable FSM; en is registered alongside state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            en         <= 1'b0;
            rcnt       <= '0;
            fcw        <= '0;
            adpll_mode <= 2'b00;
        end else begin
            if (state == RESTART) begin
                if (rcnt == '0) begin
                    state <= RUN;
                    en    <= 1'b1;
                end else begin
                    rcnt <= rcnt - 1'b1;
                end
            end
            // NOTE: later assignments in this block override the countdown above, giving CPU writes priority.
            if (wr && (sel_fcw || sel_mode)) begin
                if (sel_fcw) fcw        <= wdata[FCW_W-1:0];
                else         adpll_mode <= wdata[1:0];
                if (state != IDLE) begin
                    state <= RESTART;
                    en    <= 1'b0;
                    rcnt  <= RCNT_RELOAD;
                end
            end
            if (wr && sel_en) begin
                if (!wdata[0]) begin
                    state <= IDLE;
                    en    <= 1'b0;
                end else if (state == IDLE) begin
                    state <= RUN;
                    en    <= 1'b1;
                end
            end
        end
    end

    // Sticky lock-lost flag: set on a lock_s falling edge in RUN, cleared by a STATUS read; set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_lost <= 1'b0;
        end else if (state == RUN && lock_s_q && !lock_s) begin
            lock_lost <= 1'b1;
        end else if (rd && sel_status) begin
            lock_lost <= 1'b0;
        end
    end

`ifdef ADPLL_LOCK_TIMEOUT_EN
    localparam int TCNT_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;

    // Count unlocked RUN cycles; timeout fires once when the count reaches LOCK_TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            if (state != RUN || lock_s) begin
                tcnt <= '0;
            end else if (tcnt != TCNT_W'(LOCK_TIMEOUT)) begin
                tcnt <= tcnt + 1'b1;
            end
            if (wr && sel_en) timeout <= 1'b0;
            if (state == RUN && !lock_s && tcnt == TCNT_W'(LOCK_TIMEOUT - 1)) timeout <= 1'b1;
        end
    end
`else
    localparam int unused_lock_timeout = LOCK_TIMEOUT;
    assign timeout = 1'b0;
`endif

endmodule
